// File: rtl/ibuf_pkg.sv
// Shared constants and types for the banked input buffer.
// Read-select codes, the tile fill state and the read pipeline control word live here.
package ibuf_pkg;

   localparam logic [1:0] RPSEL_ALL   = 2'b00;
   localparam logic [1:0] RPSEL_ONE   = 2'b01;
   localparam int         IBUF_RD_LAT = 3;

   typedef enum logic {
      ST_FILL,
      ST_FULL
   } ibuf_state_t;

   // Control bits that travel alongside a read through the pipeline.
   typedef struct packed {
      logic       valid;
      logic       err;
      logic       all;
      logic [1:0] bank;
   } rd_ctrl_t;

endpackage

// File: rtl/input_buffer_if.sv
// Loader write port, router read port and tile handshake of the input buffer.
// The master side is the loader/router, the slave side is the buffer itself.
interface input_buffer_if #(
   parameter int POY = 3,
   parameter int DW  = 8
);

   logic              wr_en;
   logic              wr_ready;
   logic [1:0]        wr_bank;
   logic [1:0]        wr_row;
   logic [27:0]       wr_col;
   logic [DW-1:0]     wr_data;
   logic              blkend;
   logic              blk_release;
   logic              rd_en;
   logic [1:0]        rpsel;
   logic [1:0]        bank;
   logic [1:0]        row;
   logic [27:0]       col;
   logic [POY*DW-1:0] rdata;
   logic              rvalid;
   logic              rd_err;

   modport master (
      output wr_en, wr_bank, wr_row, wr_col, wr_data, blk_release,
      output rd_en, rpsel, bank, row, col,
      input  wr_ready, blkend, rdata, rvalid, rd_err
   );

   modport slave (
      input  wr_en, wr_bank, wr_row, wr_col, wr_data, blk_release,
      input  rd_en, rpsel, bank, row, col,
      output wr_ready, blkend, rdata, rvalid, rd_err
   );

endinterface

// File: rtl/ibuf_bank.sv
// One pixel bank: simple dual-port RAM with a registered read.
// A read and a write to the same address on one edge return the old word.
module ibuf_bank #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/input_buffer.sv
// Banked tile store between the DRAM loader and the data router.
// Tracks tile fill, pulses blkend when a tile is resident, and serves 3-cycle reads.
module input_buffer
   import ibuf_pkg::*;
#(
   parameter int POY  = 3,
   parameter int ROWS = 4,
   parameter int COLS = 64,
   parameter int DW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input_buffer_if.slave bus
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int AW    = ROW_W + COL_W;
   localparam int TOTAL = POY * ROWS * COLS;
   localparam int CNT_W = $clog2(TOTAL + 1);

   ibuf_state_t      state, state_nxt;
   logic [CNT_W-1:0] wr_cnt;
   logic             wr_in_range, wr_acc, tile_done;

   assign wr_in_range = (32'(bus.wr_bank) < 32'(POY)) && (32'(bus.wr_col) < 32'(COLS));
   assign wr_acc      = bus.wr_en && (state == ST_FILL) && wr_in_range;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_FILL;
      else     state <= state_nxt;
   end

   // Release always wins, even against the write that would complete the tile.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FILL: if (!bus.blk_release && wr_acc && (wr_cnt == CNT_W'(TOTAL - 1))) state_nxt = ST_FULL;
         ST_FULL: if (bus.blk_release) state_nxt = ST_FILL;
         default: state_nxt = ST_FILL;
      endcase
   end

   always_comb begin
      bus.wr_ready = (state == ST_FILL);
      tile_done    = (state == ST_FILL) && (state_nxt == ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt     <= '0;
         bus.blkend <= 1'b0;
      end else begin
         bus.blkend <= tile_done;
         if (bus.blk_release) wr_cnt <= '0;
         else if (wr_acc)     wr_cnt <= wr_cnt + 1'b1;
      end
   end

   // Writes are held one cycle so they reach the RAM on the same edge as a read
   // issued alongside them; that read then sees the old word.
   logic             wr_q_en;
   logic [1:0]       wr_q_bank;
   logic [AW-1:0]    wr_q_addr;
   logic [DW-1:0]    wr_q_data;

   always_ff @(posedge clk) begin
      if (rst) wr_q_en <= 1'b0;
      else     wr_q_en <= wr_acc;
   end

   always_ff @(posedge clk) begin
      wr_q_bank <= bus.wr_bank;
      wr_q_addr <= {bus.wr_row[ROW_W-1:0], bus.wr_col[COL_W-1:0]};
      wr_q_data <= bus.wr_data;
   end

   rd_ctrl_t         s1, s2;
   logic [AW-1:0]    s1_addr;
   logic             rd_req, rd_bad, rd_fire;
   logic [DW-1:0]    bank_rd [POY];
   logic [POY*DW-1:0] rd_mux;

   assign rd_req  = bus.rd_en && (bus.rpsel == RPSEL_ALL || bus.rpsel == RPSEL_ONE);
   assign rd_bad  = (32'(bus.col) >= 32'(COLS)) ||
                    (bus.rpsel == RPSEL_ONE && 32'(bus.bank) >= 32'(POY));
   assign rd_fire = s1.valid && !s1.err;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1.valid <= rd_req;
         s1.err   <= rd_bad;
         s1.all   <= (bus.rpsel == RPSEL_ALL);
         s1.bank  <= bus.bank;
         s2       <= s1;
      end
   end

   always_ff @(posedge clk) begin
      s1_addr <= {bus.row[ROW_W-1:0], bus.col[COL_W-1:0]};
   end

   for (genvar b = 0; b < POY; b++) begin : g_bank
      ibuf_bank #(
         .DEPTH (ROWS * COLS),
         .AW    (AW),
         .DW    (DW)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_q_en && (wr_q_bank == 2'(b))),
         .wr_addr (wr_q_addr),
         .wr_data (wr_q_data),
         .rd_en   (rd_fire),
         .rd_addr (s1_addr),
         .rd_data (bank_rd[b])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int b = 0; b < POY; b++) begin
         if (s2.all)                  rd_mux[b*DW +: DW] = bank_rd[b];
         else if (s2.bank == 2'(b))   rd_mux[DW-1:0]     = bank_rd[b];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rdata  <= '0;
         bus.rvalid <= 1'b0;
         bus.rd_err <= 1'b0;
      end else begin
         bus.rvalid <= s2.valid;
         bus.rd_err <= s2.valid && s2.err;
         bus.rdata  <= (s2.valid && !s2.err) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: directed fills plus random reads,
// compared every cycle against an array/queue model of the tile store.
module tb_input_buffer;
   import ibuf_pkg::*;

   localparam int POY   = 3;
   localparam int ROWS  = 4;
   localparam int COLS  = 64;
   localparam int DW    = 8;
   localparam int TOTAL = POY * ROWS * COLS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   input_buffer_if #(.POY(POY), .DW(DW)) bus();

   input_buffer #(.POY(POY), .ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit                v;
      bit                e;
      logic [POY*DW-1:0] d;
   } exp_t;

   exp_t          pipe[$];
   exp_t          none = '{v: 1'b0, e: 1'b0, d: '0};
   logic [DW-1:0] mem_m [POY][ROWS][COLS];
   int            fill_cnt = 0;
   bit            full_m   = 1'b0;
   int            n_checks = 0;
   int            n_pass   = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.wr_en = 0; bus.wr_bank = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 0;
      bus.blk_release = 0;
      bus.rd_en = 0; bus.rpsel = 0; bus.bank = 0; bus.row = 0; bus.col = 0;
   endtask

   task automatic set_wr(int idx, logic [DW-1:0] d);
      bus.wr_en   = 1;
      bus.wr_bank = 2'(idx / (ROWS * COLS));
      bus.wr_row  = 2'((idx / COLS) % ROWS);
      bus.wr_col  = 28'(idx % COLS);
      bus.wr_data = d;
   endtask

   task automatic set_rd(logic [1:0] sel, logic [1:0] b, logic [1:0] r, logic [27:0] c);
      bus.rd_en = 1; bus.rpsel = sel; bus.bank = b; bus.row = r; bus.col = c;
   endtask

   task automatic rand_rd();
      logic [27:0] c;
      case ($urandom_range(0, 9))
         0:       c = 28'(COLS + $urandom_range(0, 200));
         1:       c = 28'hFFF_FFFF;
         default: c = 28'($urandom_range(0, COLS - 1));
      endcase
      set_rd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), c);
      if ($urandom_range(0, 5) == 0) bus.rd_en = 0;
   endtask

   // One clock: predict from the driven inputs, advance, compare all outputs.
   task automatic step();
      exp_t x, got;
      bit   acc, bend;
      int   r, c;
      x.v  = bus.rd_en && (bus.rpsel == RPSEL_ALL || bus.rpsel == RPSEL_ONE);
      x.e  = 1'b0;
      x.d  = '0;
      bend = 1'b0;
      if (x.v) begin
         x.e = (bus.col >= 28'(COLS)) || (bus.rpsel == RPSEL_ONE && int'(bus.bank) >= POY);
         if (!x.e) begin
            r = int'(bus.row);
            c = int'(bus.col);
            if (bus.rpsel == RPSEL_ALL)
               for (int b = 0; b < POY; b++) x.d[b*DW +: DW] = mem_m[b][r][c];
            else
               x.d[DW-1:0] = mem_m[int'(bus.bank)][r][c];
         end
      end
      if (rst) begin
         full_m   = 1'b0;
         fill_cnt = 0;
         pipe.delete();
         repeat (IBUF_RD_LAT) pipe.push_back(none);
      end else begin
         acc = bus.wr_en && !full_m && int'(bus.wr_bank) < POY && bus.wr_col < 28'(COLS);
         if (acc) begin
            mem_m[int'(bus.wr_bank)][int'(bus.wr_row)][int'(bus.wr_col)] = bus.wr_data;
            fill_cnt++;
         end
         if (bus.blk_release) begin
            fill_cnt = 0;
            full_m   = 1'b0;
         end else if (acc && fill_cnt == TOTAL) begin
            full_m = 1'b1;
            bend   = 1'b1;
         end
         pipe.push_back(x);
      end
      @(posedge clk);
      #1;
      got = pipe.pop_front();
      check("wr_ready", 64'(bus.wr_ready), 64'(!full_m));
      check("blkend",   64'(bus.blkend),   64'(bend));
      check("rvalid",   64'(bus.rvalid),   64'(got.v));
      if (got.v) begin
         check("rd_err", 64'(bus.rd_err), 64'(got.e));
         check("rdata",  64'(bus.rdata),  64'(got.d));
      end
      if (rst) begin
         check("rst_rdata",  64'(bus.rdata),  64'd0);
         check("rst_rd_err", 64'(bus.rd_err), 64'd0);
      end
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      step();
      rst = 0;
      step();

      // First tile, data = low byte of the linear address.
      for (int i = 0; i < TOTAL; i++) begin
         idle(); set_wr(i, 8'(i)); step();
      end
      idle(); step();

      // Write while FULL must be dropped.
      idle(); set_wr(0, 8'hFF); step();
      idle(); set_rd(RPSEL_ONE, 2'd0, 2'd0, 28'd0); step();

      // Directed reads: all-bank, back-to-back single bank, error cases, no-ops.
      idle(); set_rd(RPSEL_ALL, 2'd0, 2'd2, 28'd5);  step();
      idle(); set_rd(RPSEL_ONE, 2'd0, 2'd1, 28'd9);  step();
      idle(); set_rd(RPSEL_ONE, 2'd1, 2'd1, 28'd9);  step();
      idle(); set_rd(RPSEL_ONE, 2'd2, 2'd3, 28'd63); step();
      idle(); set_rd(RPSEL_ALL, 2'd0, 2'd0, 28'd64); step();
      idle(); set_rd(RPSEL_ONE, 2'd3, 2'd0, 28'd1);  step();
      idle(); set_rd(2'b10,     2'd0, 2'd0, 28'd1);  step();
      idle(); set_rd(2'b11,     2'd1, 2'd0, 28'd1);  step();
      idle(); set_rd(RPSEL_ONE, 2'd1, 2'd0, 28'hFFF_FFFF); step();
      repeat (4) begin idle(); step(); end

      repeat (60) begin idle(); rand_rd(); step(); end

      // Reset one cycle after a read request; the request must vanish.
      idle(); set_rd(RPSEL_ALL, 2'd0, 2'd1, 28'd3); step();
      idle(); rst = 1; step();
      rst = 0;
      repeat (4) begin idle(); step(); end

      // Refill with random data, random reads and dropped writes interleaved.
      for (int i = 0; i < TOTAL; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            idle(); set_wr($urandom_range(0, TOTAL - 1), 8'($urandom));
            if ($urandom_range(0, 1) == 0) bus.wr_bank = 2'd3;
            else bus.wr_col = 28'(COLS + $urandom_range(0, 1000));
            rand_rd(); step();
         end
         idle(); set_wr(i, 8'($urandom)); rand_rd();
         if (i == 256 || i == 257) set_rd(RPSEL_ONE, 2'd1, 2'd0, 28'd0);
         step();
      end
      repeat (3) begin idle(); step(); end

      // Release while FULL reopens the buffer.
      idle(); bus.blk_release = 1; step();
      idle(); step();

      // Release coinciding with the completing write: no tile, count restarts.
      for (int i = 0; i < TOTAL - 1; i++) begin
         idle(); set_wr(i, 8'($urandom)); step();
      end
      idle(); set_wr(TOTAL - 1, 8'($urandom)); bus.blk_release = 1; step();
      repeat (3) begin idle(); step(); end

      // A full refill from zero produces blkend again.
      for (int i = 0; i < TOTAL; i++) begin
         idle(); set_wr(TOTAL - 1 - i, 8'($urandom)); rand_rd(); step();
      end
      repeat (20) begin idle(); rand_rd(); step(); end
      repeat (4) begin idle(); step(); end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
